// File: rtl/bit_modified_carry.sv
// bit_modified_carry: registered 32-bit unsigned adder, modified carry-select
// structure. Group [1:0] is a plain ripple adder; every higher group ripples
// with carry-in 0 and derives its carry-in=1 result through a binary-to-
// excess-1 converter (BEC), selected by the incoming group carry.
//
// Optional build macro: BIT_MODIFIED_CARRY_INREG_EN
//   defined   -> a/b captured in input registers first, latency 2 cycles
//   undefined -> adder fed straight from a/b, latency 1 cycle
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset (clears all flops)
//   a    in   [31:0] operand A, unsigned
//   b    in   [31:0] operand B, unsigned
//   sum  out  [31:0] registered (a+b) mod 2^32
//   cout out  registered bit 32 of a+b

// n-bit ripple-carry adder, carry-in 0, (n+1)-bit result
module bmc_rca #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N:0]   r
);
  logic c;
  always_comb begin
    r = '0;
    c = 1'b0;
    for (int i = 0; i < N; i++) begin
      r[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    r[N] = c;
  end
endmodule

// One carry-select group: ripple result and its BEC increment, muxed by cin
module bmc_bec_grp #(
  parameter int N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N:0] r0, r1;
  logic       t;

  bmc_rca #(.N(N)) u_rca (.a(a), .b(b), .r(r0));

  // BEC: bit i flips when all lower bits are 1 (XOR/AND chain, no adder)
  always_comb begin
    r1    = r0;
    r1[0] = ~r0[0];
    t     = r0[0];
    for (int i = 1; i <= N; i++) begin
      r1[i] = r0[i] ^ t;
      t     = t & r0[i];
    end
  end

  assign {cout, s} = cin ? r1 : r0;
endmodule

module bit_modified_carry (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);
  // group LSB positions; index 8 is the width sentinel
  function automatic int glsb(input int g);
    case (g)
      0:       glsb = 0;
      1:       glsb = 2;
      2:       glsb = 4;
      3:       glsb = 7;
      4:       glsb = 11;
      5:       glsb = 16;
      6:       glsb = 22;
      7:       glsb = 29;
      default: glsb = 32;
    endcase
  endfunction

  logic [31:0] op_a, op_b;

`ifdef BIT_MODIFIED_CARRY_INREG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      op_a <= a;
      op_b <= b;
    end
  end
`else
  assign op_a = a;
  assign op_b = b;
`endif

  logic [31:0] s_c;
  logic [8:0]  gc;     // gc[g] = carry into group g
  logic [2:0]  g0_r;

  bmc_rca #(.N(2)) u_g0 (.a(op_a[1:0]), .b(op_b[1:0]), .r(g0_r));

  assign gc[0]    = 1'b0;
  assign gc[1]    = g0_r[2];
  assign s_c[1:0] = g0_r[1:0];

  for (genvar g = 1; g < 8; g++) begin : g_grp
    localparam int LO = glsb(g);
    localparam int HI = glsb(g + 1) - 1;
    bmc_bec_grp #(.N(HI - LO + 1)) u_grp (
      .a   (op_a[HI:LO]),
      .b   (op_b[HI:LO]),
      .cin (gc[g]),
      .s   (s_c[HI:LO]),
      .cout(gc[g+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s_c;
      cout <= gc[8];
    end
  end
endmodule

// File: tb/tb_bit_modified_carry.sv
// Bench for bit_modified_carry: directed vector table, back-to-back and
// mid-stream reset sequences, then a random regression against a plain
// 33-bit reference sum with exact-latency checking via an expectation queue.
module tb_bit_modified_carry;
`ifdef BIT_MODIFIED_CARRY_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a   = '0;
  logic [31:0] b   = '0;
  logic [31:0] sum;
  logic        cout;

  int errors = 0;
  int checks = 0;

  bit_modified_carry dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .sum (sum),
    .cout(cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  // expectation pipeline: one entry per driven cycle
  logic [32:0] exp_q[$];
  bit          chk_q[$];

  task automatic check(input string name, input logic [32:0] got, input logic [32:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got cout=%0b sum=%08h, want cout=%0b sum=%08h",
               name, got[32], got[31:0], want[32], want[31:0]);
    end
  endtask

  // one cycle: check the result due now, then drive the next operands
  task automatic tick(input logic [31:0] na, input logic [31:0] nb,
                      input logic [32:0] want, input bit chk, input string name);
    logic [32:0] w;
    bit          c;
    @(negedge clk);
    if (exp_q.size() >= LAT) begin
      w = exp_q.pop_front();
      c = chk_q.pop_front();
      if (c) check(name, {cout, sum}, w);
    end
    a = na;
    b = nb;
    exp_q.push_back(want);
    chk_q.push_back(chk);
  endtask

  function automatic logic [32:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  vec_t vt[6];

  initial begin
    vt[0] = '{32'h00000001, 32'h00000001, 32'h00000002, 1'b0};
    vt[1] = '{32'hFFFF0006, 32'h12560006, 32'h1255000C, 1'b1};
    vt[2] = '{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vt[3] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    vt[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1};
    vt[5] = '{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};

    // reset state
    a = 32'hFFFFFFFF;
    b = 32'h00000001;
    #1;
    check("reset_async", {cout, sum}, 33'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {cout, sum}, 33'h0);
    @(negedge clk);
    rst = 1'b0;

    // directed table, each vector isolated with a flush
    foreach (vt[i]) begin
      tick(vt[i].a, vt[i].b, {vt[i].cout, vt[i].sum}, 1'b1, $sformatf("vec%0d", i));
      for (int k = 0; k < LAT; k++) tick(32'h0, 32'h0, 33'h0, 1'b0, "flush");
    end

    // back-to-back, no bubble
    tick(32'hDEDCFFFF, 32'hFEDCFFFF, {1'b1, 32'hDDB9FFFE}, 1'b1, "b2b_first");
    tick(32'h00110110, 32'h11000110, {1'b0, 32'h11110220}, 1'b1, "b2b_second");
    for (int k = 0; k < LAT; k++) tick(32'h0, 32'h0, 33'h0, 1'b1, "b2b_zero");

    // mid-stream reset: in-flight results discarded, outputs clear at once
    tick(32'hFFFFFFFF, 32'hFFFFFFFF, 33'h0, 1'b0, "pre_rst");
    tick(32'h12340003, 32'h12340003, 33'h0, 1'b0, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    check("rst_midstream", {cout, sum}, 33'h0);
    exp_q.delete();
    chk_q.delete();
    @(posedge clk);
    #1;
    check("rst_midstream_held", {cout, sum}, 33'h0);
    @(negedge clk);
    rst = 1'b0;
    // with operands held, first valid result appears exactly LAT edges later
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      if (k < LAT - 1) check("rst_release_latency", {cout, sum}, 33'h0);
    end
    check("rst_release", {cout, sum}, {1'b0, 32'h24680006});

    // random regression, streamed one pair per cycle
    for (int i = 0; i < 10500; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = ~ra;                 // all-propagate chain
        1: rb = ~ra + 32'd1;         // sum wraps to zero
        2: ra = 32'hFFFFFFFF;
        default: ;
      endcase
      tick(ra, rb, ref_add(ra, rb), 1'b1, "random");
    end
    for (int k = 0; k < LAT; k++) tick(32'h0, 32'h0, 33'h0, 1'b1, "drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
